// File: rtl/cif_arb_pkg.sv
// ---------------------------------------------------------------------------
// cif_arb_pkg
// Shared definitions for the CIF command arbiter slice.
//   - Bit positions of the source-ID field inside a command word and an
//     event word.
//   - Word types for the 64-bit command channel and the 128-bit event channel.
//   - Width of the ID field and the largest source count it can address.
// ---------------------------------------------------------------------------
package cif_arb_pkg;

    localparam int CIF_SRC_MSB     = 63;
    localparam int CIF_SRC_LSB     = 60;
    localparam int CIF_EVE_SRC_MSB = 127;
    localparam int CIF_EVE_SRC_LSB = 124;

    localparam int CIF_ID_W    = CIF_SRC_MSB - CIF_SRC_LSB + 1;
    localparam int CIF_MAX_SRC = 1 << CIF_ID_W;

    typedef logic [63:0]  cif_cmd_t;
    typedef logic [127:0] cif_eve_t;

endpackage

// File: rtl/cif_rr_arb.sv
// ---------------------------------------------------------------------------
// cif_rr_arb
// Purely combinational round-robin picker. The search starts at the slot
// named by the pointer and wraps from N-1 back to 0; the first requesting
// slot found wins.
// Ports:
//   req    in   N       request vector
//   ptr    in   IDX_W   highest-priority slot for this cycle
//   grant  out  N       one-hot winner (all zero when nothing requests)
//   idx    out  IDX_W   binary index of the winner
//   any    out  1       some slot requested
// ---------------------------------------------------------------------------
module cif_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    // Walk the slots in priority order; 'any' doubles as the found-flag so
    // later slots cannot override an earlier winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/cif_cmd_arb.sv
// ---------------------------------------------------------------------------
// cif_cmd_arb
// Shares the single 64-bit CIF command channel between NUM_REQ requesters.
// Each command is tagged with its source ID, and the 128-bit events that come
// back are routed to the source that issued the command. The number of
// unanswered commands per source is limited to MAX_OUTS.
//
// Optional feature macro: CIF_CMD_ARB_STAT_EN adds per-source grant
// statistics, read through stat_sel / stat_grant_cnt.
//
// Ports:
//   ext_clk         in   1            clock
//   ext_reset       in   1            asynchronous reset, active high
//   req_valid       in   NUM_REQ      per-source command valid
//   req_data        in   NUM_REQ*64   per-source command; [63:60] replaced by the ID
//   req_ready       out  NUM_REQ      one-hot accept to the granted source
//   cmd_valid       out  1            command register valid
//   cmd_data        out  64           {source ID, req_data[59:0]}
//   cmd_ready       in   1            command FIFO can accept
//   eve_valid       in   1            event available
//   eve_data        in   128          event; [127:124] is the source ID
//   eve_ready       out  1            event accepted this cycle
//   rsp_valid       out  NUM_REQ      per-source event valid
//   rsp_data        out  128          shared event bus
//   rsp_ready       in   NUM_REQ      per-source event accept
//   err_bad_eve     out  1            sticky unmatched-event flag
//   stat_sel        in   4            (stat build only) source to read
//   stat_grant_cnt  out  32           (stat build only) grant count of stat_sel
// ---------------------------------------------------------------------------
module cif_cmd_arb
    import cif_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_OUTS = 8
) (
    input  logic                  ext_clk,
    input  logic                  ext_reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*64-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  cmd_valid,
    output logic [63:0]           cmd_data,
    input  logic                  cmd_ready,
    input  logic                  eve_valid,
    input  logic [127:0]          eve_data,
    output logic                  eve_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [127:0]          rsp_data,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic                  err_bad_eve
`ifdef CIF_CMD_ARB_STAT_EN
   ,input  logic [3:0]            stat_sel,
    output logic [31:0]           stat_grant_cnt
`endif
);

    localparam int         IDX_W   = $clog2(NUM_REQ);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTS);

    logic [7:0]             out_cnt [NUM_REQ];
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant_vec;
    logic                   grant_any;
    logic                   load_ok;
    logic                   grant_fire;
    logic [59:0]            grant_payload;
    logic                   unused_src_bits;
    logic [CIF_MAX_SRC-1:0] cnt_nz;
    logic [CIF_ID_W-1:0]    eve_id;
    logic [NUM_REQ-1:0]     eve_onehot;
    logic                   eve_fire;
    logic                   eve_good;
    logic                   rsp_drain;
    logic [NUM_REQ-1:0]     inc_vec;
    logic [NUM_REQ-1:0]     dec_vec;
    cif_eve_t               rsp_reg;

    // A source may compete only while it still has headroom in its
    // outstanding-command budget.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (out_cnt[i] < MAX_CNT);
        end
    end

    cif_rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant_vec),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Grant only when the command register is free or drains this cycle.
    // Reset also blocks the handshake so nothing is accepted while the
    // registers are being cleared.
    always_comb begin
        load_ok    = !cmd_valid || cmd_ready;
        grant_fire = load_ok && grant_any && !ext_reset;
        req_ready  = grant_fire ? grant_vec : '0;
        inc_vec    = req_ready;
    end

    // AND-OR select of the winner's payload; the top nibble of each source
    // word is replaced by the tag, so those bits are just folded away.
    always_comb begin
        grant_payload   = '0;
        unused_src_bits = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                grant_payload = req_data[i*64 +: 60];
            end
            unused_src_bits = unused_src_bits ^ (^req_data[i*64+60 +: 4]);
        end
    end

    // Event-side decode. cnt_nz is padded to the full 16-entry ID space with
    // zeros, so an ID beyond NUM_REQ naturally reads as "nothing outstanding"
    // and is treated as unmatched.
    always_comb begin
        cnt_nz     = '0;
        eve_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_nz[i] = (out_cnt[i] != 8'd0);
        end
        eve_id = eve_data[CIF_EVE_SRC_MSB:CIF_EVE_SRC_LSB];
        for (int i = 0; i < NUM_REQ; i++) begin
            eve_onehot[i] = (eve_id == CIF_ID_W'(i));
        end
        rsp_drain = |(rsp_valid & rsp_ready);
        eve_ready = !ext_reset && ((rsp_valid == '0) || rsp_drain);
        eve_fire  = eve_valid && eve_ready;
        eve_good  = cnt_nz[eve_id];
        dec_vec   = (eve_fire && eve_good) ? eve_onehot : '0;
    end

    // Outstanding counters: a grant and a matched event for the same source
    // in one cycle cancel out.
    always_ff @(posedge ext_clk or posedge ext_reset) begin
        if (ext_reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    out_cnt[i] <= out_cnt[i] + 8'd1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    out_cnt[i] <= out_cnt[i] - 8'd1;
                end
            end
        end
    end

    // Command output register and round-robin pointer. The pointer moves to
    // the slot after the winner, so the winner has lowest priority next time.
    always_ff @(posedge ext_clk or posedge ext_reset) begin
        if (ext_reset) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            rr_ptr    <= '0;
        end else if (grant_fire) begin
            cmd_valid <= 1'b1;
            cmd_data  <= {CIF_ID_W'(grant_idx), grant_payload};
            rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Event output register. Only one event is held at a time, so a stalled
    // source blocks every later event regardless of its destination.
    always_ff @(posedge ext_clk or posedge ext_reset) begin
        if (ext_reset) begin
            rsp_valid   <= '0;
            rsp_reg     <= '0;
            err_bad_eve <= 1'b0;
        end else begin
            if (eve_fire && eve_good) begin
                rsp_valid <= eve_onehot;
                rsp_reg   <= eve_data;
            end else if (rsp_drain) begin
                rsp_valid <= '0;
            end
            if (eve_fire && !eve_good) begin
                err_bad_eve <= 1'b1;
            end
        end
    end

    assign rsp_data = rsp_reg;

`ifdef CIF_CMD_ARB_STAT_EN
    logic [31:0] grant_tot [NUM_REQ];
    logic [31:0] stat_pick;

    // Free-running per-source grant counters; wrap at 2^32.
    always_ff @(posedge ext_clk or posedge ext_reset) begin
        if (ext_reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_tot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i]) begin
                    grant_tot[i] <= grant_tot[i] + 32'd1;
                end
            end
        end
    end

    // Selects beyond the populated sources fall through to zero.
    always_comb begin
        stat_pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == 4'(i)) begin
                stat_pick = grant_tot[i];
            end
        end
    end

    always_ff @(posedge ext_clk or posedge ext_reset) begin
        if (ext_reset) begin
            stat_grant_cnt <= '0;
        end else begin
            stat_grant_cnt <= stat_pick;
        end
    end
`endif

endmodule
